spike_scheduler: RTL and testbench

- Per-core spike scheduler that sits directly upstream of the core's token controller.
- Buffers incoming axon spike packets in a ring of NUM_TICKS rows (one NUM_AXONS-bit row per future tick).
- Presents the current tick's row as axon_spikes while the token controller processes it.
- Retires that row on scheduler_clr.
- Driven by the token controller's scheduler_set/scheduler_clr and by the router's local-delivery write port.

---
 rtl/sched_pkg.sv | 22 ++
 rtl/sched_ring_mem.sv | 41 ++++
 rtl/spike_scheduler.sv | 101 ++++++++++
 tb/tb_spike_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared widths, defaults and packet field layout for the spike scheduler
package sched_pkg;

  localparam int DEF_NUM_AXONS = 256;
  localparam int DEF_NUM_TICKS = 16;

  // Packet layout is {delay, axon}; the axon index sits at the LSBs.
  localparam int AXON_LSB = 0;

  function automatic int calc_axon_w(input int num_axons);
    return (num_axons > 1) ? $clog2(num_axons) : 1;
  endfunction

  function automatic int calc_delay_w(input int num_ticks);
    return (num_ticks > 1) ? $clog2(num_ticks) : 1;
  endfunction

  function automatic int calc_delay_lsb(input int num_axons);
    return AXON_LSB + calc_axon_w(num_axons);
  endfunction

endpackage

// File: rtl/sched_ring_mem.sv
// rtl/sched_ring_mem.sv - tick ring of axon rows with OR-in bit write, row clear and async read
module sched_ring_mem
  import sched_pkg::*;
#(
  parameter int NUM_AXONS = DEF_NUM_AXONS,
  parameter int NUM_TICKS = DEF_NUM_TICKS,
  parameter int AXON_W    = calc_axon_w(NUM_AXONS),
  parameter int DELAY_W   = calc_delay_w(NUM_TICKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DELAY_W-1:0]   wr_row,
  input  logic [AXON_W-1:0]    wr_axon,
  input  logic                 clr_en,
  input  logic [DELAY_W-1:0]   clr_row,
  input  logic [DELAY_W-1:0]   rd_row,
  output logic [NUM_AXONS-1:0] rd_data
);

  logic [NUM_AXONS-1:0] rows_q [NUM_TICKS];

  // Legal traffic never writes and clears the same row in one cycle; the write is last so it would win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TICKS; i++) begin
        rows_q[i] <= '0;
      end
    end else begin
      if (clr_en) begin
        rows_q[clr_row] <= '0;
      end
      if (wr_en) begin
        rows_q[wr_row][wr_axon] <= 1'b1;
      end
    end
  end

  assign rd_data = rows_q[rd_row];

endmodule

// File: rtl/spike_scheduler.sv
// rtl/spike_scheduler.sv - per-core spike scheduler: tick pointer, set/clr FSM, sticky error
module spike_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_AXONS = DEF_NUM_AXONS,
  parameter int NUM_TICKS = DEF_NUM_TICKS,
  parameter int AXON_W    = calc_axon_w(NUM_AXONS),
  parameter int DELAY_W   = calc_delay_w(NUM_TICKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wen,
  input  logic [DELAY_W+AXON_W-1:0]   packet_in,
  input  logic                        set,
  input  logic                        clr,
  output logic [NUM_AXONS-1:0]        axon_spikes,
  output logic [DELAY_W-1:0]          tick_index,
  output logic                        busy,
  output logic                        error
);

  localparam int DELAY_LSB = AXON_LSB + AXON_W;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [DELAY_W-1:0]   ptr_q, ptr_d;
  logic                 error_q, error_d;
  logic                 clr_en;
  logic                 wr_en;
  logic [DELAY_W-1:0]   pkt_delay;
  logic [AXON_W-1:0]    pkt_axon;
  logic [DELAY_W-1:0]   wr_row;

  assign pkt_delay = packet_in[DELAY_LSB +: DELAY_W];
  assign pkt_axon  = packet_in[AXON_LSB +: AXON_W];
  // Ring depth is a power of two, so natural overflow gives the modulo.
  assign wr_row    = ptr_q + pkt_delay;
  assign wr_en     = wen && (pkt_delay != '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    error_d = error_q;
    clr_en  = 1'b0;
    if (set && clr) begin
      error_d = 1'b1;
    end else if (set) begin
      if (state_q == ST_ACTIVE) error_d = 1'b1;
      else                      state_d = ST_ACTIVE;
    end else if (clr) begin
      if (state_q == ST_ACTIVE) begin
        state_d = ST_IDLE;
        clr_en  = 1'b1;
        ptr_d   = ptr_q + DELAY_W'(1);
      end else begin
        error_d = 1'b1;
      end
    end
    if (wen && (pkt_delay == '0)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      error_q <= error_d;
    end
  end

  sched_ring_mem #(
    .NUM_AXONS (NUM_AXONS),
    .NUM_TICKS (NUM_TICKS),
    .AXON_W    (AXON_W),
    .DELAY_W   (DELAY_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_axon (pkt_axon),
    .clr_en  (clr_en),
    .clr_row (ptr_q),
    .rd_row  (ptr_q),
    .rd_data (axon_spikes)
  );

  assign tick_index = ptr_q;
  assign busy       = (state_q == ST_ACTIVE);
  assign error      = error_q;

endmodule

// File: tb/tb_spike_scheduler.sv
// tb/tb_spike_scheduler.sv - directed bench with reference ring model and tick scoreboard
module tb_spike_scheduler;

  localparam int NA = 256;
  localparam int NT = 16;
  localparam int AW = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wen = 1'b0;
  logic [DW+AW-1:0] packet_in = '0;
  logic          set = 1'b0;
  logic          clr = 1'b0;
  logic [NA-1:0] axon_spikes;
  logic [DW-1:0] tick_index;
  logic          busy;
  logic          error;

  spike_scheduler #(.NUM_AXONS(NA), .NUM_TICKS(NT)) dut (
    .clk         (clk),
    .rst         (rst),
    .wen         (wen),
    .packet_in   (packet_in),
    .set         (set),
    .clr         (clr),
    .axon_spikes (axon_spikes),
    .tick_index  (tick_index),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tick;
    logic [NA-1:0] row;
  } exp_t;

  exp_t          sb[$];
  logic [NA-1:0] m_rows [NT];
  int            m_ptr;
  bit            m_busy;
  bit            m_err;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string tag, input logic [NA-1:0] obs, input logic [NA-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_rows[i] = '0;
    m_ptr = 0;
    m_busy = 0;
    m_err = 0;
    sb.delete();
  endtask

  task automatic check_state();
    exp_t e;
    check("tick_index", NA'(tick_index), NA'(m_ptr));
    check("busy", NA'(busy), NA'(m_busy));
    check("error", NA'(error), NA'(m_err));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_tick", NA'(tick_index), NA'(e.tick));
      check("sb_row", axon_spikes, e.row);
    end
  endtask

  task automatic do_reset(input bit noise);
    rst = 1'b1;
    wen = noise; set = noise; clr = 1'b0;
    packet_in = {DW'(1), AW'(3)};
    @(posedge clk); #1;
    rst = 1'b0; wen = 1'b0; set = 1'b0;
    model_reset();
    check_state();
    check("reset_row", axon_spikes, '0);
  endtask

  task automatic cyc(input bit w, input int d, input int a, input bit s, input bit c);
    int old;
    bit do_clr;
    exp_t e;
    old = m_ptr;
    do_clr = 0;
    if (s && c) m_err = 1;
    else if (s) begin
      if (m_busy) m_err = 1; else m_busy = 1;
    end else if (c) begin
      if (!m_busy) m_err = 1; else do_clr = 1;
    end
    if (w) begin
      if (d == 0) m_err = 1;
      else m_rows[(old + d) % NT][a] = 1'b1;
    end
    if (do_clr) begin
      m_rows[old] = '0;
      m_ptr = (old + 1) % NT;
      m_busy = 0;
      e.tick = m_ptr;
      e.row = m_rows[m_ptr];
      sb.push_back(e);
    end
    wen = w; set = s; clr = c;
    packet_in = {DW'(d), AW'(a)};
    @(posedge clk); #1;
    wen = 1'b0; set = 1'b0; clr = 1'b0;
    check_state();
  endtask

  task automatic tick_pass();
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [NA-1:0] v;
    model_reset();
    @(posedge clk); #1;
    do_reset(1'b1);

    // delay=1 packet shows up as the next tick's row
    cyc(1, 1, 5, 0, 0);
    tick_pass();
    check("t1_index", NA'(tick_index), NA'(1));
    v = '0; v[5] = 1'b1;
    check("t1_row", axon_spikes, v);

    do_reset(1'b0);
    cyc(1, 3, 0, 0, 0);
    cyc(1, 3, 255, 0, 0);
    cyc(1, 3, 255, 0, 0);
    for (int i = 0; i < 3; i++) tick_pass();
    v = '0; v[0] = 1'b1; v[255] = 1'b1;
    check("t3_row", axon_spikes, v);
    tick_pass();
    for (int i = 4; i < 15; i++) tick_pass();
    check("t15_index", NA'(tick_index), NA'(15));
    cyc(1, 2, 9, 0, 0);
    tick_pass();
    check("wrap_index", NA'(tick_index), NA'(0));
    tick_pass();
    v = '0; v[9] = 1'b1;
    check("wrap_row1", axon_spikes, v);
    tick_pass();
    tick_pass();
    check("retired_row3", axon_spikes, '0);

    // write coincident with clr at tick 4
    cyc(1, 1, 20, 0, 0);
    tick_pass();
    check("t4_index", NA'(tick_index), NA'(4));
    v = '0; v[20] = 1'b1;
    check("t4_row", axon_spikes, v);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 7, 0, 1);
    v = '0; v[7] = 1'b1;
    check("t5_row", axon_spikes, v);
    check("row4_cleared", dut.u_mem.rows_q[4], '0);
    check("no_error_yet", NA'(error), NA'(0));

    cyc(1, 0, 11, 0, 0);
    check("delay0_err", NA'(error), NA'(1));
    check("delay0_drop", axon_spikes, v);
    do_reset(1'b0);

    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("set_busy_err", NA'(error), NA'(1));
    check("set_busy_stay", NA'(busy), NA'(1));
    do_reset(1'b0);

    cyc(0, 0, 0, 0, 1);
    check("clr_idle_err", NA'(error), NA'(1));
    check("clr_idle_index", NA'(tick_index), NA'(0));
    do_reset(1'b0);
    check("rst_clears_err", NA'(error), NA'(0));

    cyc(0, 0, 0, 1, 1);
    check("setclr_err", NA'(error), NA'(1));
    check("setclr_idle", NA'(busy), NA'(0));
    do_reset(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
